// File: rtl/cmi_enc_if.sv
// cmi_enc_if: valid/ready word handshake into the CMI encoder.
interface cmi_enc_if #(parameter int DATA_W = 8) ();
  logic [DATA_W-1:0] data_word;
  logic              data_valid;
  logic              data_ready;
  modport master (output data_word, data_valid, input data_ready);
  modport slave  (input data_word, data_valid, output data_ready);
endinterface

// File: rtl/cmi_enc.sv
// cmi_enc: MSB-first serialiser emitting one 2-bit CMI symbol per clock.
// Define CMI_ENC_MARK_EN to prefix every word with the 10 marker (code violation).
module cmi_enc #(
  parameter int DATA_W = 8
) (
  input  logic       clk_sig,
  input  logic       reset_sig,
  cmi_enc_if.slave   bus,
  output logic [1:0] encode_sig,
  output logic       sym_valid,
  output logic       sym_mark,
  output logic       busy
);
  localparam int CW = DATA_W > 1 ? $clog2(DATA_W) : 1;
`ifdef CMI_ENC_MARK_EN
  typedef enum logic [1:0] {IDLE, SHIFT, MARK} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif
  state_t            r_state, w_state;
  logic [CW-1:0]     r_cnt, w_cnt;
  logic [DATA_W-1:0] r_sh, w_sh;
  logic              r_pol, w_pol;
  logic [1:0]        r_enc, w_enc;
  logic              r_sv, w_sv;
  logic              w_acc, w_emit, w_bit, w_mk;

  assign bus.data_ready = (r_state == IDLE) || (r_state == SHIFT && r_cnt == '0);
  assign w_acc          = bus.data_valid && bus.data_ready;

  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_sh    = r_sh;
    w_emit  = 1'b0;
    w_bit   = 1'b0;
    w_mk    = 1'b0;
`ifdef CMI_ENC_MARK_EN
    if (w_acc) begin
      w_mk    = 1'b1;
      w_sh    = bus.data_word;
      w_state = MARK;
    end else if (r_state == MARK) begin
      w_emit  = 1'b1;
      w_bit   = r_sh[DATA_W-1];
      w_sh    = r_sh << 1;
      w_cnt   = CW'(DATA_W-1);
      w_state = SHIFT;
    end
`else
    if (w_acc) begin
      w_emit  = 1'b1;
      w_bit   = bus.data_word[DATA_W-1];
      w_sh    = bus.data_word << 1;
      w_cnt   = CW'(DATA_W-1);
      w_state = SHIFT;
    end
`endif
    else if (r_state == SHIFT && r_cnt != '0) begin
      w_emit = 1'b1;
      w_bit  = r_sh[DATA_W-1];
      w_sh   = r_sh << 1;
      w_cnt  = r_cnt - CW'(1);
    end else if (r_state == SHIFT) w_state = IDLE;
    // a 1 takes 11/00 by polarity and flips it; the marker leaves polarity alone
    w_pol = r_pol ^ (w_emit & w_bit);
    w_enc = w_mk ? 2'b10 : !(w_emit && w_bit) ? 2'b01 : r_pol ? 2'b00 : 2'b11;
    w_sv  = w_emit | w_mk;
  end

  always_ff @(posedge clk_sig or posedge reset_sig) begin
    if (reset_sig) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_sh    <= '0;
      r_pol   <= 1'b0;
      r_enc   <= 2'b01;
      r_sv    <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_sh    <= w_sh;
      r_pol   <= w_pol;
      r_enc   <= w_enc;
      r_sv    <= w_sv;
    end
  end

`ifdef CMI_ENC_MARK_EN
  logic r_mk;
  always_ff @(posedge clk_sig or posedge reset_sig) begin
    if (reset_sig) r_mk <= 1'b0;
    else r_mk <= w_mk;
  end
  assign sym_mark = r_mk;
`else
  assign sym_mark = 1'b0;
`endif

  assign encode_sig = r_enc;
  assign sym_valid  = r_sv;
  assign busy       = r_state != IDLE;
endmodule

// File: doc/cmi_enc.md
Name: cmi_enc

Overview:
- Upstream neighbour of the CMI decoder.
- Accepts parallel data words through a valid/ready handshake and serialises them MSB-first.
- Emits one 2-bit CMI symbol per clock on encode_sig:
  - binary 0 -> 01.
  - binary 1 -> alternately 11 / 00, driven by a persistent polarity flip-flop.
- Feeds the decoder's encode_sig input directly.

Parameters:
- DATA_W, 8, data word width in bits (legal range 1..32).

Ports:
- clk_sig  in  1  clock; all state updates on its rising edge.
- reset_sig  in  1  asynchronous reset, active-high.
- data_word  in  DATA_W  parallel word to encode, MSB is sent first.
- data_valid  in  1  data_word is valid this cycle.
- data_ready  out  1  encoder can accept a word this cycle (combinational).
- encode_sig  out  2  registered CMI symbol, [1] is the first half-bit.
- sym_valid  out  1  encode_sig carries a data (or marker) symbol.
- sym_mark  out  1  encode_sig carries the marker symbol 10; tied 0 when the optional feature is off.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset is asynchronous and active-high. While reset_sig=1:
  - state=IDLE, pol=0, bit_cnt=0, shift register=0.
  - encode_sig=2'b01, sym_valid=0, sym_mark=0, busy=0.
  - data_ready is driven to 1 immediately after reset deasserts.
- States: IDLE, SHIFT, plus MARK when the optional feature is compiled in.
- Handshake:
  - A word is accepted at a rising edge where data_valid=1 and data_ready=1.
  - data_ready = (state==IDLE) or (state==SHIFT and bit_cnt==0).
  - data_word is sampled only at the accept edge; changes to data_word after that edge have no effect.
- Symbol mapping, for bit b with the current pol:
  - b=0 -> 01, pol unchanged.
  - b=1 -> 11 if pol==0, else 00; pol toggles.
  - pol persists across words and idle gaps; only reset clears it.
- Accept edge (feature off):
  - encode_sig <= symbol(data_word[DATA_W-1]), sym_valid <= 1.
  - Remaining DATA_W-1 bits are loaded into the shift register, bit_cnt <= DATA_W-1, state <= SHIFT.
- Latency: the first symbol is visible in the cycle after the accept edge.
- SHIFT with bit_cnt>0: each edge outputs the next bit's symbol and decrements bit_cnt.
- SHIFT with bit_cnt==0 (last symbol currently on encode_sig):
  - If a new word is accepted, it loads as above. This gives back-to-back operation with no gap symbol.
  - Otherwise: state <= IDLE, encode_sig <= 01, sym_valid <= 0.
- IDLE without accept: encode_sig holds 01, sym_valid=0, pol unchanged.
- Width rules:
  - bit_cnt width = max(1, clog2(DATA_W)).
  - DATA_W=1: bit_cnt stays 0, data_ready is high in every state, and continuous streaming is supported.
- Reset mid-word: the word is aborted with no partial completion. All outputs and pol return to their reset values at once.
- busy=1 in SHIFT/MARK.
- Symbol 10 is never emitted except as the marker.

Optional Feature:
- Macro: CMI_ENC_MARK_EN.
- When defined:
  - Every accepted word is preceded by one marker symbol 10 (a CMI code violation), used as a word delimiter.
  - On the accept edge: encode_sig <= 10, sym_valid <= 1, sym_mark <= 1, the full word is loaded, state <= MARK.
  - The next edge outputs the MSB symbol and enters SHIFT with bit_cnt = DATA_W-1.
  - Each word occupies DATA_W+1 symbol slots.
  - The marker does not affect pol.
- When undefined: the MARK state does not exist, sym_mark is constant 0, and the timing is as in Behaviour.

Test Plan:
- Reset, then DATA_W=8, word 8'hB2 accepted -> encode_sig sequence 11,01,00,11,01,01,00,01 on 8 consecutive cycles with sym_valid=1, then 01 with sym_valid=0; pol ends at 0.
- Word 8'h80, idle 5 cycles, word 8'h80 -> first word gives 11 then 01 x7; second word's first symbol is 00, showing polarity held across idle.
- data_valid held high with 8'hFF, 8'hFF -> 16 contiguous symbols alternating 11,00,...; data_ready high only on the last-symbol cycle of each word; no gap symbol.
- Assert reset_sig asynchronously (mid-cycle) after 3 symbols of 8'hFF -> encode_sig=01, sym_valid=0, busy=0 immediately, without waiting for a clock edge; next word 8'h80 starts with 11.
- DATA_W=1, data_valid=1 with a bit pattern 1,1,0,1 -> 11,00,01,11 back-to-back, data_ready constantly 1.
- With CMI_ENC_MARK_EN, word 8'h01 -> symbols 10 (sym_mark=1), 01 x7, 11; 9 slots total; the next word's marker appears immediately if offered.
